autocorr_lag_sequencer: RTL and testbench
=========================================

// Module: autocorr_lag_sequencer
// PURPOSE
//  Sequences the bipolar multiply-accumulate datapath over a stored frame of signed 12-bit samples.
//  Computes r[lag] = sum_{n=0}^{N_SAMPLES-1-lag} x[n]*x[n+lag] for every lag LAG_MIN..LAG_MAX.
//  Reads the sample RAM through two synchronous read ports and emits one 36-bit sum per lag with a valid/ready handshake.
//  Sits between the frame capture buffer and the pitch-decision logic.
// PARAMETERS
//  N_SAMPLES  1024  samples per frame
//  ADDR_W     10    sample RAM address width; 2^ADDR_W >= N_SAMPLES
//  LAG_MIN    20    first lag computed; must be >= 1
//  LAG_MAX    400   last lag computed; LAG_MIN <= LAG_MAX < N_SAMPLES
//  LAG_W      9     lag index width; 2^LAG_W > LAG_MAX
// PORTS
//  clk        in   1       system clock
//  rst        in   1       asynchronous, active-high reset
//  start      in   1       begin a frame; sampled only in IDLE
//  busy       out  1       high from the cycle after start was accepted until DONE is left
//  done       out  1       one-cycle pulse after the last lag is accepted
//  rd_en      out  1       RAM read strobe; data returns the next cycle
//  rd_addr_a  out  ADDR_W  address of x[n]
//  rd_addr_b  out  ADDR_W  address of x[n+lag]
//  rd_data_a  in   12      two's-complement x[n], valid 1 cycle after rd_en
//  rd_data_b  in   12      two's-complement x[n+lag], valid 1 cycle after rd_en
//  lag_valid  out  1       lag_idx/lag_sum valid
//  lag_ready  in   1       consumer accepts when lag_valid && lag_ready
//  lag_idx    out  LAG_W   lag of current result
//  lag_sum    out  36      signed r[lag]
//  best_lag   out  LAG_W   (AUTOCORR_PEAK_TRACK_EN only) lag of maximum r
//  best_sum   out  36      (AUTOCORR_PEAK_TRACK_EN only) maximum r
// BEHAVIOUR
//  Reset: state IDLE; every output 0; internal lag counter = LAG_MIN; accumulator = 0.
//  FSM IDLE -> CLEAR -> RUN -> DRAIN -> EMIT -> (CLEAR | DONE) -> IDLE.
//  IDLE:  start=1 -> CLEAR. start is ignored in all other states.
//  CLEAR: accumulator = 0; n = 0. Goes to RUN next cycle.
//  RUN:   each cycle drive rd_en=1, rd_addr_a=n, rd_addr_b=n+lag, then n++.
//         After issuing n = N_SAMPLES-1-lag, go to DRAIN.
//  MAC:   on the cycle after each rd_en, acc <= acc + sext36(rd_data_a*rd_data_b).
//         The product is the exact signed 24-bit result; accumulation wraps modulo 2^36.
//         Max magnitude is N_SAMPLES*2^22, so wrap never occurs at default parameters.
//  DRAIN: 1 cycle; absorbs the final product; rd_en=0.
//  EMIT:  lag_valid=1; lag_idx=lag; lag_sum=acc. These hold stable until lag_ready=1.
//         No reads are issued while waiting.
//         On acceptance: lag_valid drops next cycle.
//         If lag == LAG_MAX -> DONE, else lag++ -> CLEAR.
//  DONE:  done=1 for one cycle; busy=0 from the next cycle; -> IDLE.
//  Latency per lag: (N_SAMPLES-lag) read cycles + CLEAR + DRAIN + >=1 EMIT cycle.
//  rd_en and the addresses are 0 outside RUN.
//  rst asserted mid-frame: immediate return to reset values, with no partial lag_valid.
//  Outputs other than lag_valid/done hold their last value between frames.
// CONFIGURATION
//  Macro AUTOCORR_PEAK_TRACK_EN.
//  Defined:
//   - best_sum is set to -2^35 and best_lag to LAG_MIN in CLEAR of the first lag.
//   - On each EMIT acceptance, if lag_sum > best_sum (signed, strict), both are updated.
//     Ties therefore keep the smallest lag.
//   - Final values are valid in the cycle done pulses and hold until the next start.
//  Undefined: best_lag/best_sum ports and their logic are absent. All other timing is identical.
// STRUCTURE
//  Shared package: SAMPLE_W=12, ACC_W=36, FSM state encoding (IDLE, CLEAR, RUN, DRAIN, EMIT, DONE).
//  One sub-module, corr_mac_stage: signed 12x12 multiply, sign-extend, 36-bit accumulate.
//  It has clear and enable inputs, so the arithmetic is testable in isolation.
// TESTING
//  Use N_SAMPLES=16, LAG_MIN=1, LAG_MAX=3, lag_ready tied 1 unless stated.
//  1. All samples +1 -> lag_sum 15, 14, 13 for lags 1, 2, 3; then one done pulse.
//  2. Alternating +1/-1 -> lag_sum -15, +14, -13.
//     With the macro: best_lag=2, best_sum=14.
//  3. All samples -2048 -> lag 1 sum = 15*4194304 = 62914560 (no sign or width error).
//     Also x[0]=2047 and x[1]=-2048, others 0 -> lag 1 sum = -4192256.
//  4. Hold lag_ready=0 for 5 cycles at lag 2 -> lag_valid, lag_idx and lag_sum stable; rd_en=0 throughout.
//  5. Assert rst during RUN of lag 2 -> all outputs 0 immediately. A subsequent start recomputes from lag 1.
//  6. Pulse start while busy -> ignored, with no restart or change to results.
//     Lag 1 read count is 15 rd_en cycles, with address pairs (0,1)..(14,15).

Source files
------------

// File: rtl/autocorr_lag_sequencer_pkg.sv
// Shared definitions for the autocorrelation lag sequencer.
//   SAMPLE_W  : width of a stored sample (signed)
//   PROD_W    : width of an exact sample*sample product
//   ACC_W     : width of the per-lag accumulator / result
//   state_t   : sequencer FSM encoding
//   sext_prod : sign-extends a product to the accumulator width
package autocorr_lag_sequencer_pkg;

  localparam int SAMPLE_W = 12;
  localparam int PROD_W   = 2 * SAMPLE_W;
  localparam int ACC_W    = 36;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    EMIT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/autocorr_lag_sequencer_if.sv
// Bus bundle for the autocorrelation lag sequencer.
//   control : start (in), busy, done (out)
//   RAM     : rd_en, rd_addr_a, rd_addr_b (out); rd_data_a, rd_data_b (in, 1 cycle after rd_en)
//   results : lag_valid, lag_idx, lag_sum (out); lag_ready (in)
//   peak    : best_lag, best_sum (out), present only with AUTOCORR_PEAK_TRACK_EN
// Modport master is the sequencer side; slave is the RAM/consumer/controller side.
interface autocorr_lag_sequencer_if #(
  parameter int ADDR_W = 10,
  parameter int LAG_W  = 9
);
  import autocorr_lag_sequencer_pkg::*;

  logic                       start;
  logic                       busy;
  logic                       done;
  logic                       rd_en;
  logic [ADDR_W-1:0]          rd_addr_a;
  logic [ADDR_W-1:0]          rd_addr_b;
  logic signed [SAMPLE_W-1:0] rd_data_a;
  logic signed [SAMPLE_W-1:0] rd_data_b;
  logic                       lag_valid;
  logic                       lag_ready;
  logic [LAG_W-1:0]           lag_idx;
  logic signed [ACC_W-1:0]    lag_sum;
`ifdef AUTOCORR_PEAK_TRACK_EN
  logic [LAG_W-1:0]           best_lag;
  logic signed [ACC_W-1:0]    best_sum;

  modport master (
    input  start, rd_data_a, rd_data_b, lag_ready,
    output busy, done, rd_en, rd_addr_a, rd_addr_b,
           lag_valid, lag_idx, lag_sum, best_lag, best_sum
  );
  modport slave (
    output start, rd_data_a, rd_data_b, lag_ready,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b,
           lag_valid, lag_idx, lag_sum, best_lag, best_sum
  );
`else
  modport master (
    input  start, rd_data_a, rd_data_b, lag_ready,
    output busy, done, rd_en, rd_addr_a, rd_addr_b,
           lag_valid, lag_idx, lag_sum
  );
  modport slave (
    output start, rd_data_a, rd_data_b, lag_ready,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b,
           lag_valid, lag_idx, lag_sum
  );
`endif

endinterface

// File: rtl/corr_mac_stage.sv
// Bipolar multiply-accumulate stage.
//   clk, rst : clock, asynchronous active-high reset (acc -> 0)
//   clr      : synchronous accumulator clear (has priority over en)
//   en       : add a*b into the accumulator this cycle
//   a, b     : signed samples
//   acc      : signed running sum, wraps modulo 2^ACC_W
module corr_mac_stage
  import autocorr_lag_sequencer_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] a,
  input  logic signed [SAMPLE_W-1:0] b,
  output logic signed [ACC_W-1:0]    acc
);

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;
  logic signed [PROD_W-1:0] prod;

  // Widen before multiplying; the low PROD_W bits of the product are exact
  // because |a*b| <= 2^22 fits a signed 24-bit value.
  assign a_ext = {{(PROD_W-SAMPLE_W){a[SAMPLE_W-1]}}, a};
  assign b_ext = {{(PROD_W-SAMPLE_W){b[SAMPLE_W-1]}}, b};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + sext_prod(prod);
    end
  end

endmodule

// File: rtl/autocorr_lag_sequencer.sv
// Autocorrelation lag sequencer: for each lag LAG_MIN..LAG_MAX streams the pairs
// (x[n], x[n+lag]) out of a two-port synchronous sample RAM, accumulates their
// products and hands r[lag] to the consumer over a valid/ready handshake.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : autocorr_lag_sequencer_if.master (start/busy/done, RAM read
//              port, result stream, and best_lag/best_sum when
//              AUTOCORR_PEAK_TRACK_EN is defined)
// Optional feature macro: AUTOCORR_PEAK_TRACK_EN (running peak of r over lags).
module autocorr_lag_sequencer
  import autocorr_lag_sequencer_pkg::*;
#(
  parameter int N_SAMPLES = 1024,
  parameter int ADDR_W    = 10,
  parameter int LAG_MIN   = 20,
  parameter int LAG_MAX   = 400,
  parameter int LAG_W     = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  autocorr_lag_sequencer_if.master bus
);

  localparam logic [LAG_W-1:0]  LAG_MIN_V = LAG_W'(LAG_MIN);
  localparam logic [LAG_W-1:0]  LAG_MAX_V = LAG_W'(LAG_MAX);
  localparam logic [ADDR_W-1:0] N_LAST_V  = ADDR_W'(N_SAMPLES - 1);

  state_t                  state_reg;
  state_t                  state_next;
  logic [LAG_W-1:0]        lag_reg;
  logic [ADDR_W-1:0]       n_reg;
  logic                    rd_en_d_reg;
  logic [LAG_W-1:0]        lag_idx_hold_reg;
  logic signed [ACC_W-1:0] lag_sum_hold_reg;
  logic signed [ACC_W-1:0] acc;

  logic [ADDR_W-1:0]       lag_addr;
  logic [ADDR_W-1:0]       n_last;
  logic                    in_run;
  logic                    in_emit;
  logic                    accept;
  logic                    last_lag;

  // lag < N_SAMPLES <= 2^ADDR_W, so the lag always fits an address.
  assign lag_addr = ADDR_W'(lag_reg);
  assign n_last   = N_LAST_V - lag_addr;
  assign in_run   = (state_reg == RUN);
  assign in_emit  = (state_reg == EMIT);
  assign accept   = in_emit && bus.lag_ready;
  assign last_lag = (lag_reg == LAG_MAX_V);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = CLEAR;
      CLEAR:   state_next = RUN;
      RUN:     if (n_reg == n_last) state_next = DRAIN;
      DRAIN:   state_next = EMIT;
      EMIT:    if (bus.lag_ready) state_next = last_lag ? DONE : CLEAR;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- index counters and result holding ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lag_reg          <= LAG_MIN_V;
      n_reg            <= '0;
      rd_en_d_reg      <= 1'b0;
      lag_idx_hold_reg <= '0;
      lag_sum_hold_reg <= '0;
    end else begin
      // Read data lands one cycle after the strobe, so the MAC enable lags rd_en.
      rd_en_d_reg <= in_run;
      case (state_reg)
        IDLE:  if (bus.start) lag_reg <= LAG_MIN_V;
        CLEAR: n_reg <= '0;
        RUN:   n_reg <= n_reg + ADDR_W'(1);
        EMIT: begin
          if (bus.lag_ready) begin
            lag_idx_hold_reg <= lag_reg;
            lag_sum_hold_reg <= acc;
            // Rewind after the final lag so the next frame starts clean.
            lag_reg <= last_lag ? LAG_MIN_V : lag_reg + LAG_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  corr_mac_stage u_mac (
    .clk (clk),
    .rst (rst),
    .clr (state_reg == CLEAR),
    .en  (rd_en_d_reg),
    .a   (bus.rd_data_a),
    .b   (bus.rd_data_b),
    .acc (acc)
  );

  // ---------------- outputs ----------------
  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = (state_reg == DONE);
  assign bus.rd_en     = in_run;
  assign bus.rd_addr_a = in_run ? n_reg : '0;
  assign bus.rd_addr_b = in_run ? (n_reg + lag_addr) : '0;
  assign bus.lag_valid = in_emit;
  // Live values while offering a result; otherwise the last accepted one, so
  // the result ports stay quiet while the next lag is being accumulated.
  assign bus.lag_idx   = in_emit ? lag_reg : lag_idx_hold_reg;
  assign bus.lag_sum   = in_emit ? acc : lag_sum_hold_reg;

`ifdef AUTOCORR_PEAK_TRACK_EN
  logic [LAG_W-1:0]        best_lag_reg;
  logic signed [ACC_W-1:0] best_sum_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_lag_reg <= '0;
      best_sum_reg <= '0;
    end else if ((state_reg == CLEAR) && (lag_reg == LAG_MIN_V)) begin
      // Most negative value, so the first accepted lag always wins.
      best_lag_reg <= LAG_MIN_V;
      best_sum_reg <= {1'b1, {(ACC_W-1){1'b0}}};
    end else if (accept && (acc > best_sum_reg)) begin
      // Strict compare: ties keep the earlier (smaller) lag.
      best_lag_reg <= lag_reg;
      best_sum_reg <= acc;
    end
  end

  assign bus.best_lag = best_lag_reg;
  assign bus.best_sum = best_sum_reg;
`endif

endmodule

// File: tb/tb_autocorr_lag_sequencer.sv
// Self-checking bench for autocorr_lag_sequencer with a 16-sample frame, lags 1..3.
module tb_autocorr_lag_sequencer;
  import autocorr_lag_sequencer_pkg::*;

  localparam int N    = 16;
  localparam int AW   = 4;
  localparam int LMIN = 1;
  localparam int LMAX = 3;
  localparam int LW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  autocorr_lag_sequencer_if #(.ADDR_W(AW), .LAG_W(LW)) bus ();

  autocorr_lag_sequencer #(
    .N_SAMPLES (N),
    .ADDR_W    (AW),
    .LAG_MIN   (LMIN),
    .LAG_MAX   (LMAX),
    .LAG_W     (LW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Sample RAM model: registered read, data valid the cycle after rd_en.
  logic signed [SAMPLE_W-1:0] mem [N];
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_data_a <= mem[bus.rd_addr_a];
      bus.rd_data_b <= mem[bus.rd_addr_b];
    end
  end

  typedef struct {
    int     lag;
    longint sum;
  } exp_t;

  typedef struct {
    int     pat;
    longint s1;
    longint s2;
    longint s3;
    int     best_lag;
    longint best_sum;
  } vec_t;

  exp_t    sb_q[$];
  vec_t    vecs[4];
  int      n_vec  = 0;
  int      n_miss = 0;
  int      done_cnt = 0;
  int      rd_cnt   = 0;
  logic [AW-1:0] log_a [512];
  logic [AW-1:0] log_b [512];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and observe what the DUT does this cycle.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.done) done_cnt++;
    if (bus.rd_en) begin
      log_a[rd_cnt % 512] = bus.rd_addr_a;
      log_b[rd_cnt % 512] = bus.rd_addr_b;
      rd_cnt++;
    end
    if (bus.lag_valid && bus.lag_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", longint'(bus.lag_idx), -1);
      end else begin
        e = sb_q.pop_front();
        $display("result lag %0d sum %0d (expect lag %0d sum %0d)",
                 bus.lag_idx, bus.lag_sum, e.lag, e.sum);
        check("lag_idx", longint'(bus.lag_idx), longint'(e.lag));
        check("lag_sum", longint'(bus.lag_sum), e.sum);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},      longint'(bus.busy), 0);
    check({tag, "_done"},      longint'(bus.done), 0);
    check({tag, "_rd_en"},     longint'(bus.rd_en), 0);
    check({tag, "_rd_addr_a"}, longint'(bus.rd_addr_a), 0);
    check({tag, "_rd_addr_b"}, longint'(bus.rd_addr_b), 0);
    check({tag, "_lag_valid"}, longint'(bus.lag_valid), 0);
    check({tag, "_lag_idx"},   longint'(bus.lag_idx), 0);
    check({tag, "_lag_sum"},   longint'(bus.lag_sum), 0);
`ifdef AUTOCORR_PEAK_TRACK_EN
    check({tag, "_best_lag"},  longint'(bus.best_lag), 0);
    check({tag, "_best_sum"},  longint'(bus.best_sum), 0);
`endif
  endtask

  task automatic load_pattern(input int p);
    for (int i = 0; i < N; i++) begin
      case (p)
        0: mem[i] = 12'sh001;
        1: mem[i] = (i % 2 == 0) ? 12'sh001 : 12'shFFF;
        2: mem[i] = 12'sh800;
        3: mem[i] = (i == 0) ? 12'sh7FF : ((i == 1) ? 12'sh800 : 12'sh000);
        default: mem[i] = 12'($urandom_range(0, 4095));
      endcase
    end
  endtask

  task automatic push_exp(input int lag, input longint sum);
    exp_t e;
    e.lag = lag;
    e.sum = sum;
    sb_q.push_back(e);
  endtask

  task automatic start_frame();
    @(posedge clk); #1 bus.start = 1'b1;
    tick();
    @(posedge clk); #1 bus.start = 1'b0;
    tick();
    check("busy_after_start", longint'(bus.busy), 1);
  endtask

  task automatic finish_frame(input string tag, input int d0, input int exp_best_lag,
                              input longint exp_best_sum);
    bit found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (bus.done) found = 1;
      else tick();
    end
    check({tag, "_done_seen"}, longint'(found), 1);
    if (found) begin
`ifdef AUTOCORR_PEAK_TRACK_EN
      check({tag, "_best_lag"}, longint'(bus.best_lag), longint'(exp_best_lag));
      check({tag, "_best_sum"}, longint'(bus.best_sum), exp_best_sum);
`else
      if (exp_best_lag < 0 || exp_best_sum < -(64'sd1 <<< 40)) $display("note: bad best args");
`endif
      tick();
      check({tag, "_busy_after_done"}, longint'(bus.busy), 0);
      check({tag, "_done_pulse_len"},  longint'(bus.done), 0);
      check({tag, "_done_count"},      longint'(done_cnt - d0), 1);
    end
    check({tag, "_sb_empty"}, longint'(sb_q.size()), 0);
  endtask

  task automatic wait_valid_idx(input string tag, input int idx);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (bus.lag_valid && (int'(bus.lag_idx) == idx)) found = 1;
    end
    check({tag, "_wait_lag_valid"}, longint'(found), 1);
  endtask

  initial begin
    int     d0;
    int     r0;
    longint s;
    longint best_s;
    int     best_l;

    vecs[0] = '{pat: 0, s1: 15,       s2: 14,       s3: 13,       best_lag: 1, best_sum: 15};
    vecs[1] = '{pat: 1, s1: -15,      s2: 14,       s3: -13,      best_lag: 2, best_sum: 14};
    vecs[2] = '{pat: 2, s1: 62914560, s2: 58720256, s3: 54525952, best_lag: 1, best_sum: 62914560};
    vecs[3] = '{pat: 3, s1: -4192256, s2: 0,        s3: 0,        best_lag: 2, best_sum: 0};

    bus.start     = 1'b0;
    bus.lag_ready = 1'b1;
    rst           = 1'b1;
    tick();
    tick();
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    tick();
    check("idle_busy", longint'(bus.busy), 0);

    // Table-driven frames with hand-computed sums.
    for (int v = 0; v < 4; v++) begin
      load_pattern(vecs[v].pat);
      push_exp(1, vecs[v].s1);
      push_exp(2, vecs[v].s2);
      push_exp(3, vecs[v].s3);
      d0 = done_cnt;
      start_frame();
      finish_frame($sformatf("vec%0d", v), d0, vecs[v].best_lag, vecs[v].best_sum);
    end

    // Random frame checked against a direct evaluation of the sum.
    load_pattern(4);
    best_s = -(64'sd1 <<< 35);
    best_l = LMIN;
    for (int lag = LMIN; lag <= LMAX; lag++) begin
      s = 0;
      for (int n = 0; n <= N - 1 - lag; n++) s += longint'(mem[n]) * longint'(mem[n + lag]);
      push_exp(lag, s);
      if (s > best_s) begin
        best_s = s;
        best_l = lag;
      end
    end
    d0 = done_cnt;
    start_frame();
    finish_frame("random", d0, best_l, best_s);

    // Backpressure at lag 2: result must hold and no reads may be issued.
    load_pattern(0);
    push_exp(1, 15); push_exp(2, 14); push_exp(3, 13);
    d0 = done_cnt;
    start_frame();
    wait_valid_idx("stall_lag1", 1);
    @(posedge clk); #1 bus.lag_ready = 1'b0;
    tick();
    begin
      bit found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
        if (bus.lag_valid) found = 1;
        else tick();
      end
      check("stall_wait_lag2", longint'(found), 1);
    end
    for (int c = 0; c < 5; c++) begin
      check("stall_lag_valid", longint'(bus.lag_valid), 1);
      check("stall_lag_idx",   longint'(bus.lag_idx), 2);
      check("stall_lag_sum",   longint'(bus.lag_sum), 14);
      check("stall_rd_en",     longint'(bus.rd_en), 0);
      tick();
    end
    @(posedge clk); #1 bus.lag_ready = 1'b1;
    tick();
    finish_frame("stall", d0, 1, 15);

    // Reset while lag 2 is reading, then a fresh frame must start at lag 1.
    load_pattern(0);
    push_exp(1, 15); push_exp(2, 14); push_exp(3, 13);
    start_frame();
    wait_valid_idx("rst_lag1", 1);
    tick();
    tick();
    tick();
    check("rst_in_run", longint'(bus.rd_en), 1);
    rst = 1'b1;
    #1;
    check_zero("midrun_rst");
    sb_q.delete();
    tick();
    @(posedge clk); #1 rst = 1'b0;
    tick();
    load_pattern(1);
    push_exp(1, -15); push_exp(2, 14); push_exp(3, -13);
    d0 = done_cnt;
    start_frame();
    finish_frame("after_rst", d0, 2, 14);

    // start pulsed while busy must not restart the frame.
    load_pattern(0);
    push_exp(1, 15); push_exp(2, 14); push_exp(3, 13);
    d0 = done_cnt;
    r0 = rd_cnt;
    start_frame();
    tick();
    tick();
    tick();
    @(posedge clk); #1 bus.start = 1'b1;
    tick();
    @(posedge clk); #1 bus.start = 1'b0;
    tick();
    wait_valid_idx("busy_start_lag1", 1);
    check("lag1_read_count", longint'(rd_cnt - r0), 15);
    for (int i = 0; i < 15; i++) begin
      check($sformatf("lag1_addr_a[%0d]", i), longint'(log_a[(r0 + i) % 512]), longint'(i));
      check($sformatf("lag1_addr_b[%0d]", i), longint'(log_b[(r0 + i) % 512]), longint'(i + 1));
    end
    finish_frame("busy_start", d0, 1, 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
